// File: rtl/sopc_mem_arbiter_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter:
// FSM state and grant encodings plus the SOPC bus widths.
package sopc_mem_arbiter_pkg;

    localparam int SOPC_ADDR_W = 32;
    localparam int SOPC_DATA_W = 32;

    typedef enum logic [1:0] {
        ArbIdle  = 2'd0,
        ArbIInfl = 2'd1,
        ArbDInfl = 2'd2
    } arb_state_e;

    typedef enum logic {
        GrantI = 1'b0,
        GrantD = 1'b1
    } grant_e;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select between the fetch and data ports.
// ARB_RR_EN selects round-robin on conflict; otherwise the data port wins.
module arb_pick
    import sopc_mem_arbiter_pkg::*;
(
    input  logic   i_elig_i,
    input  logic   d_elig_i,
`ifdef ARB_RR_EN
    input  grant_e last_grant_i,
`endif
    output logic   valid_o,
    output grant_e grant_o
);

    assign valid_o = i_elig_i | d_elig_i;

    always_comb begin
        grant_o = GrantI;
        if (d_elig_i && !i_elig_i) begin
            grant_o = GrantD;
        end else if (d_elig_i && i_elig_i) begin
`ifdef ARB_RR_EN
            grant_o = (last_grant_i == GrantD) ? GrantI : GrantD;
`else
            grant_o = GrantD;
`endif
        end
    end

endmodule

// File: rtl/sopc_mem_arbiter.sv
// Shares one single-port synchronous RAM between the fetch and load/store ports.
// Define ARB_RR_EN for round-robin conflict resolution (default: data port priority).
module sopc_mem_arbiter
    import sopc_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = SOPC_ADDR_W,
    parameter int DATA_W = SOPC_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ack,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_stall,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W/8-1:0] d_sel,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_stall,
    output logic                mem_ce,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_sel,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    arb_state_e state_q, state_d;
    logic       i_elig, d_elig, grant_valid;
    grant_e     grant;

    assign i_ack = (state_q == ArbIInfl);
    assign d_ack = (state_q == ArbDInfl);

    // A port being acked still holds req high and must not be re-granted.
    // Gating with rst makes mem_ce and the stalls drop as soon as reset asserts.
    assign i_elig = rst & i_req & ~i_ack;
    assign d_elig = rst & d_req & ~d_ack;

    assign i_stall = rst & i_req & ~i_ack;
    assign d_stall = rst & d_req & ~d_ack;

    assign i_rdata = rst ? mem_rdata : '0;
    assign d_rdata = rst ? mem_rdata : '0;

`ifdef ARB_RR_EN
    grant_e last_grant_q;

    arb_pick u_pick (
        .i_elig_i    (i_elig),
        .d_elig_i    (d_elig),
        .last_grant_i(last_grant_q),
        .valid_o     (grant_valid),
        .grant_o     (grant)
    );
`else
    arb_pick u_pick (
        .i_elig_i(i_elig),
        .d_elig_i(d_elig),
        .valid_o (grant_valid),
        .grant_o (grant)
    );
`endif

    always_comb begin
        mem_ce    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_sel   = '0;
        mem_wdata = '0;
        state_d   = ArbIdle;
        if (grant_valid) begin
            mem_ce = 1'b1;
            if (grant == GrantD) begin
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_sel   = d_sel;
                mem_wdata = d_wdata;
                state_d   = ArbDInfl;
            end else begin
                mem_addr = i_addr;
                mem_sel  = '1;
                state_d  = ArbIInfl;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ArbIdle;
`ifdef ARB_RR_EN
            last_grant_q <= GrantI;
`endif
        end else begin
            state_q <= state_d;
`ifdef ARB_RR_EN
            if (grant_valid) begin
                last_grant_q <= grant;
            end
`endif
        end
    end

endmodule

// File: tb/tb_sopc_mem_arbiter.sv
// Scoreboard bench for sopc_mem_arbiter: directed timing checks followed by
// randomized concurrent fetch/load/store traffic against a word-array reference.
module tb_sopc_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_ack, i_stall;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_ack, d_stall;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_sel;
    logic        mem_ce, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_sel;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic [31:0] data;
    } d_exp_t;

    logic [31:0] exp_i[$];
    d_exp_t      exp_d[$];
    logic [31:0] ram     [0:255];
    logic [31:0] ref_mem [0:255];

    always #5 clk = ~clk;

    sopc_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_sel(d_sel), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Single-port synchronous RAM with registered read.
    always @(posedge clk) begin
        if (mem_ce && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_sel[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end else if (mem_ce) begin
            mem_rdata <= ram[mem_addr[9:2]];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: data-port accesses complete in issue order, so the
    // expected response can be computed when the request is presented.
    task automatic push_d(input logic we, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] wd);
        d_exp_t e;
        e.we = we;
        e.data = 32'h0;
        if (we) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[a[9:2]][8*b +: 8] = wd[8*b +: 8];
        end else begin
            e.data = ref_mem[a[9:2]];
        end
        exp_d.push_back(e);
    endtask

    // Monitor: stall/idle-output rules each cycle, scoreboard pop on every ack.
    d_exp_t mon_e;
    logic [31:0] mon_i;
    always @(negedge clk) begin
        if (rst) begin
            chk("i_stall", {63'h0, i_stall}, {63'h0, i_req & ~i_ack});
            chk("d_stall", {63'h0, d_stall}, {63'h0, d_req & ~d_ack});
            if (!mem_ce)
                chk("idle_mem_fields", {23'h0, mem_we, mem_sel, mem_addr}, 64'h0);
            if (i_ack) begin
                if (exp_i.size() == 0) begin
                    chk("i_ack_unexpected", 64'h1, 64'h0);
                end else begin
                    mon_i = exp_i.pop_front();
                    $display("I ack rdata=%08h expect=%08h", i_rdata, mon_i);
                    chk("i_rdata", {32'h0, i_rdata}, {32'h0, mon_i});
                end
            end
            if (d_ack) begin
                if (exp_d.size() == 0) begin
                    chk("d_ack_unexpected", 64'h1, 64'h0);
                end else begin
                    mon_e = exp_d.pop_front();
                    $display("D ack we=%0b rdata=%08h expect=%08h", mon_e.we, d_rdata, mon_e.data);
                    if (!mon_e.we) chk("d_rdata", {32'h0, d_rdata}, {32'h0, mon_e.data});
                end
            end
        end
    end

    task automatic do_fetch(input logic [31:0] a, input int gap);
        bit got = 0;
        exp_i.push_back(ref_mem[a[9:2]]);
        i_req = 1'b1;
        i_addr = a;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (i_ack) begin
                got = 1;
                break;
            end
        end
        chk("i_timeout", {63'h0, got}, 64'h1);
        tick();
        i_req = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic do_data(input logic we, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] wd, input int gap);
        bit got = 0;
        push_d(we, a, s, wd);
        d_req = 1'b1;
        d_we = we;
        d_addr = a;
        d_sel = s;
        d_wdata = wd;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (d_ack) begin
                got = 1;
                break;
            end
        end
        chk("d_timeout", {63'h0, got}, 64'h1);
        tick();
        d_req = 1'b0;
        repeat (gap) tick();
    endtask

    int i_cnt, d_cnt;

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i] = (i * 32'h9E3779B1) ^ 32'h5A5A0000;
            ref_mem[i] = ram[i];
        end
        ram[16] = 32'h3C010001;
        ref_mem[16] = 32'h3C010001;
        mem_rdata = 32'h0;

        // Reset with both ports requesting: all outputs low.
        rst = 1'b0;
        i_req = 1'b1; i_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104; d_sel = 4'hF; d_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_strobes", {58'h0, i_ack, d_ack, i_stall, d_stall, mem_ce, mem_we}, 64'h0);
        chk("rst_mem_bus", {28'h0, mem_sel, mem_addr}, 64'h0);
        chk("rst_wdata", {32'h0, mem_wdata}, 64'h0);
        chk("rst_rdata", {i_rdata, d_rdata}, 64'h0);

        // Release: first grant to D, conflict loser I issues while D is acked.
        push_d(1'b0, 32'h104, 4'hF, 32'h0);
        exp_i.push_back(ref_mem[16]);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("first_grant_ce", {63'h0, mem_ce}, 64'h1);
        chk("first_grant_d", {32'h0, mem_addr}, 64'h104);
        tick();
        @(negedge clk);
        chk("conflict_d_ack", {63'h0, d_ack}, 64'h1);
        chk("conflict_i_issue", {31'h0, mem_ce, mem_addr}, {31'h0, 1'b1, 32'h40});
        chk("conflict_i_stall", {62'h0, i_stall, d_stall}, 64'h2);
        tick();
        d_req = 1'b0;
        @(negedge clk);
        chk("conflict_i_ack", {62'h0, i_ack, i_stall}, 64'h2);
        tick();
        i_req = 1'b0;
        tick();

        // Single fetch.
        exp_i.push_back(ref_mem[16]);
        i_req = 1'b1; i_addr = 32'h40;
        @(negedge clk);
        chk("fetch_issue", {26'h0, mem_ce, mem_we, mem_sel, mem_addr}, {26'h0, 1'b1, 1'b0, 4'hF, 32'h40});
        chk("fetch_stall_n", {62'h0, i_stall, i_ack}, 64'h2);
        tick();
        @(negedge clk);
        chk("fetch_ack", {62'h0, i_ack, i_stall}, 64'h2);
        chk("fetch_rdata", {32'h0, i_rdata}, 64'h3C010001);
        chk("fetch_no_regrant", {63'h0, mem_ce}, 64'h0);
        tick();
        i_req = 1'b0;
        tick();

        // Store then load to the same address.
        push_d(1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_sel = 4'hF; d_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("store_issue", {30'h0, mem_ce, mem_we, mem_addr}, {30'h0, 2'b11, 32'h100});
        chk("store_wdata", {28'h0, mem_sel, mem_wdata}, {28'h0, 4'hF, 32'hDEADBEEF});
        tick();
        @(negedge clk);
        chk("store_ack", {62'h0, d_ack, mem_ce}, 64'h2);
        tick();
        push_d(1'b0, 32'h100, 4'hF, 32'h0);
        d_we = 1'b0;
        @(negedge clk);
        chk("load_issue", {62'h0, mem_ce, mem_we}, 64'h2);
        tick();
        @(negedge clk);
        chk("load_ack", {63'h0, d_ack}, 64'h1);
        chk("load_rdata", {32'h0, d_rdata}, 64'hDEADBEEF);
        tick();
        d_req = 1'b0;
        tick();

        // Leave I as last granted, then hold both ports busy for 20 cycles.
        do_fetch(32'h20, 1);
        for (int k = 0; k < 10; k++) begin
            exp_i.push_back(ref_mem[32'h80 >> 2]);
            push_d(1'b0, 32'h180, 4'hF, 32'h0);
        end
        i_cnt = 0; d_cnt = 0;
        i_req = 1'b1; i_addr = 32'h80;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h180; d_sel = 4'hF;
        for (int c = 0; c <= 20; c++) begin
            @(negedge clk);
            if (c < 20) begin
                chk("contend_ce", {63'h0, mem_ce}, 64'h1);
                chk("contend_order", {32'h0, mem_addr}, (c % 2 == 0) ? 64'h180 : 64'h80);
            end
            if (c >= 1) begin
                if (i_ack) i_cnt++;
                if (d_ack) d_cnt++;
            end
            tick();
            if (c == 19) d_req = 1'b0;
            if (c == 20) i_req = 1'b0;
        end
        chk("contend_d_acks", 64'(d_cnt), 64'd10);
        chk("contend_i_acks", 64'(i_cnt), 64'd10);
        tick();

        // Reset during the issue cycle of a load.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1A0; d_sel = 4'hF;
        @(negedge clk);
        chk("mid_rst_issue", {63'h0, mem_ce}, 64'h1);
        #1 rst = 1'b0;
        #1 chk("mid_rst_ce_drop", {63'h0, mem_ce}, 64'h0);
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_no_ack", {62'h0, i_ack, d_ack}, 64'h0);
        tick();
        rst = 1'b1;
        push_d(1'b0, 32'h1A0, 4'hF, 32'h0);
        @(negedge clk);
        chk("reissue_from_idle", {63'h0, mem_ce}, 64'h1);
        tick();
        @(negedge clk);
        chk("reissue_ack", {63'h0, d_ack}, 64'h1);
        chk("reissue_rdata", {32'h0, d_rdata}, {32'h0, ref_mem[32'h1A0 >> 2]});
        tick();
        d_req = 1'b0;
        tick();

        // Randomized concurrent traffic: fetches from 0x000-0x0FC, data in 0x100-0x1FC.
        fork
            begin
                for (int n = 0; n < 60; n++)
                    do_fetch({22'h0, 2'b00, 6'($urandom_range(0, 63)), 2'b00}, $urandom_range(0, 3));
            end
            begin
                for (int n = 0; n < 60; n++)
                    do_data(1'($urandom_range(0, 1)), {22'h0, 2'b01, 6'($urandom_range(0, 63)), 2'b00},
                            4'($urandom_range(1, 15)), $urandom, $urandom_range(0, 3));
            end
        join
        repeat (3) tick();
        chk("drain_i", 64'(exp_i.size()), 64'd0);
        chk("drain_d", 64'(exp_d.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
